// File: rtl/load_store_unit_pkg.sv
// ---------------------------------------------------------------------------
// load_store_unit_pkg
// Shared definitions for the load/store unit: FSM state encoding, funct3
// size/sign encodings and the memory map bases.
// ---------------------------------------------------------------------------
package load_store_unit_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        ACCESS    = 3'd1,
        RMW_READ  = 3'd2,
        RMW_WRITE = 3'd3,
        DONE      = 3'd4
    } lsu_state_e;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [31:0] LSU_ROM_BASE = 32'h0040_0000;
    localparam logic [31:0] LSU_RAM_BASE = 32'h1001_0000;

    // funct3 values a request may legally carry; unsigned sizes only make
    // sense for loads.
    function automatic logic f3_legal(input logic [2:0] f3, input logic is_store);
        logic ok;
        ok = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
             (!is_store && ((f3 == F3_BU) || (f3 == F3_HU)));
        return ok;
    endfunction

endpackage

// File: rtl/lsu_align.sv
// ---------------------------------------------------------------------------
// lsu_align
// Combinational lane handling for the load/store unit.
//   word_i   : 32-bit word read from memory
//   lane_i   : byte offset of the access within the word
//   funct3_i : access size and signedness
//   wdata_i  : right-justified store data
//   load_o   : selected lane, sign- or zero-extended
//   merge_o  : word_i with the target lane replaced by store data
// ---------------------------------------------------------------------------
module lsu_align
    import load_store_unit_pkg::*;
(
    input  logic [31:0] word_i,
    input  logic [1:0]  lane_i,
    input  logic [2:0]  funct3_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] load_o,
    output logic [31:0] merge_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = word_i[{lane_i, 3'b000} +: 8];
        half_sel = lane_i[1] ? word_i[31:16] : word_i[15:0];

        load_o = word_i;
        case (funct3_i)
            F3_B:    load_o = {{24{byte_sel[7]}}, byte_sel};
            F3_BU:   load_o = {24'h00_0000, byte_sel};
            F3_H:    load_o = {{16{half_sel[15]}}, half_sel};
            F3_HU:   load_o = {16'h0000, half_sel};
            default: load_o = word_i;
        endcase

        merge_o = word_i;
        if (funct3_i[1:0] == 2'b00) begin
            merge_o[{lane_i, 3'b000} +: 8] = wdata_i[7:0];
        end else if (funct3_i[1:0] == 2'b01) begin
            merge_o[{lane_i[1], 4'b0000} +: 16] = wdata_i[15:0];
        end
    end

endmodule

// File: rtl/load_store_unit.sv
// ---------------------------------------------------------------------------
// load_store_unit
// Sequences single load/store accesses onto a word-wide memory port with a
// combinational read path. Sub-word stores are done as read-modify-write.
//   clk, reset   : system clock, asynchronous active-low reset
//   req_i        : request, sampled only in IDLE
//   we_i         : 1 = store, 0 = load
//   funct3_i     : size/sign of the access
//   addr_i       : byte address
//   wdata_i      : right-justified store data
//   busy_o       : unit is not idle
//   done_o       : one-cycle completion pulse
//   rdata_o      : extended load result, held until the next load completes
//   misaligned_o : with done_o, access misaligned or funct3 illegal
//   fault_o      : with done_o, store into ROM space
//   mem_*        : word-aligned memory port
//
// state     | meaning
// ----------+--------------------------------------------------------------
// IDLE      | waiting for req_i
// ACCESS    | load lane capture, or full-word store write
// RMW_READ  | read the word to be partially overwritten, build merged word
// RMW_WRITE | write the merged word
// DONE      | done_o pulse with error flags, then back to IDLE
// ---------------------------------------------------------------------------
module load_store_unit
    import load_store_unit_pkg::*;
#(
    parameter int                    DATA_WIDTH = 32,
    parameter logic [DATA_WIDTH-1:0] RAM_BASE   = LSU_RAM_BASE
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_i,
    input  logic                  we_i,
    input  logic [2:0]            funct3_i,
    input  logic [DATA_WIDTH-1:0] addr_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic [DATA_WIDTH-1:0] rdata_o,
    output logic                  misaligned_o,
    output logic                  fault_o,
    output logic                  mem_we_o,
    output logic [DATA_WIDTH-1:0] mem_addr_o,
    output logic [DATA_WIDTH-1:0] mem_wdata_o,
    input  logic [DATA_WIDTH-1:0] mem_rdata_i
);

    lsu_state_e            state_q;
    logic                  we_q;
    logic [2:0]            f3_q;
    logic [1:0]            lane_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic                  busy_q;
    logic                  done_q;
    logic                  mis_q;
    logic                  fault_q;
    logic                  mem_we_q;
    logic [DATA_WIDTH-1:0] rdata_q;
    logic [DATA_WIDTH-1:0] mem_addr_q;
    logic [DATA_WIDTH-1:0] mem_wdata_q;

    logic                  req_mis;
    logic                  req_fault;
    logic                  req_sub_store;
    logic [DATA_WIDTH-1:0] load_val;
    logic [DATA_WIDTH-1:0] merge_val;

    // Classification of the incoming request; misalignment includes illegal
    // funct3 and wins over the ROM fault.
    always_comb begin
        req_mis = !f3_legal(funct3_i, we_i) ||
                  ((funct3_i[1:0] == 2'b01) && addr_i[0]) ||
                  ((funct3_i[1:0] == 2'b10) && (addr_i[1:0] != 2'b00));
        req_fault     = we_i && (addr_i < RAM_BASE);
        req_sub_store = we_i && (funct3_i[1:0] != 2'b10);
    end

    lsu_align u_align (
        .word_i   (mem_rdata_i),
        .lane_i   (lane_q),
        .funct3_i (f3_q),
        .wdata_i  (wdata_q),
        .load_o   (load_val),
        .merge_o  (merge_val)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            we_q        <= 1'b0;
            f3_q        <= 3'b000;
            lane_q      <= 2'b00;
            wdata_q     <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            mis_q       <= 1'b0;
            fault_q     <= 1'b0;
            mem_we_q    <= 1'b0;
            rdata_q     <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req_i) begin
                        we_q       <= we_i;
                        f3_q       <= funct3_i;
                        lane_q     <= addr_i[1:0];
                        wdata_q    <= wdata_i;
                        busy_q     <= 1'b1;
                        mem_addr_q <= {addr_i[DATA_WIDTH-1:2], 2'b00};
                        if (req_mis) begin
                            mis_q   <= 1'b1;
                            done_q  <= 1'b1;
                            state_q <= DONE;
                        end else if (req_fault) begin
                            fault_q <= 1'b1;
                            done_q  <= 1'b1;
                            state_q <= DONE;
                        end else if (req_sub_store) begin
                            state_q <= RMW_READ;
                        end else begin
                            // A full-word store writes during ACCESS, so the
                            // enable and data are registered on entry.
                            if (we_i) begin
                                mem_we_q    <= 1'b1;
                                mem_wdata_q <= wdata_i;
                            end
                            state_q <= ACCESS;
                        end
                    end
                end
                ACCESS: begin
                    if (!we_q) begin
                        rdata_q <= load_val;
                    end
                    mem_we_q    <= 1'b0;
                    mem_wdata_q <= '0;
                    done_q      <= 1'b1;
                    state_q     <= DONE;
                end
                RMW_READ: begin
                    // Read word captured already merged with the store lane.
                    mem_wdata_q <= merge_val;
                    mem_we_q    <= 1'b1;
                    state_q     <= RMW_WRITE;
                end
                RMW_WRITE: begin
                    mem_we_q    <= 1'b0;
                    mem_wdata_q <= '0;
                    done_q      <= 1'b1;
                    state_q     <= DONE;
                end
                DONE: begin
                    done_q  <= 1'b0;
                    mis_q   <= 1'b0;
                    fault_q <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    done_q   <= 1'b0;
                    mis_q    <= 1'b0;
                    fault_q  <= 1'b0;
                    busy_q   <= 1'b0;
                    mem_we_q <= 1'b0;
                    state_q  <= IDLE;
                end
            endcase
        end
    end

    assign busy_o       = busy_q;
    assign done_o       = done_q;
    assign rdata_o      = rdata_q;
    assign misaligned_o = mis_q;
    assign fault_o      = fault_q;
    assign mem_we_o     = mem_we_q;
    assign mem_addr_o   = mem_addr_q;
    assign mem_wdata_o  = mem_wdata_q;

endmodule
